cpu_mem_responder: RTL and testbench

- Data-memory responder for the 16-bit CPU.
- Sits at the far end of the CPU load/store interface and services STW and LDW requests against a local synchronous RAM.
- Single outstanding transaction, valid/ready handshake on both the request and response channels, fixed programmable response latency.

---
 rtl/cpu_mem_responder_if.sv | 39 +++
 rtl/cpu_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder_if
//  Description : Load/store request/response bus between the 16-bit CPU and
//                its data-memory responder. Request and response channels
//                each use a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    // Request channel (CPU -> responder)
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response channel (responder -> CPU)
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // CPU side of the bus
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

    // Responder side of the bus
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_responder
//  Description : Data-memory responder for the 16-bit CPU. Services STW/LDW
//                requests against a local synchronous RAM, one transaction
//                in flight, with a fixed response latency of LATENCY cycles
//                from the request accept edge.
//  Options     : define CPU_MEM_BOUNDS_ERR_EN to report out-of-range
//                accesses on rsp_err (otherwise rsp_err is tied low).
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,   // RAM words, must be <= 2**ADDR_W
    parameter int LATENCY = 2      // 1..15
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cpu_mem_responder_if.slave mem_if,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]       c_CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              rsp_we_q,    rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef CPU_MEM_BOUNDS_ERR_EN
    logic              rsp_err_q,   rsp_err_d;
`endif

    // RAM contents are deliberately not reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_idle;
    logic              w_accept;
    logic              w_req_in_range;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_in_range;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_enter_resp;

    // Request decode, response source selection and RAM read port.
    // With LATENCY == 1 the response is formed on the accept edge itself, so
    // the live request fields feed the response path while in IDLE; in every
    // other state the latched copies are used.
    always_comb begin
        w_idle         = (state_q == S_IDLE);
        w_accept       = w_idle && mem_if.req_valid;
        w_req_in_range = ({1'b0, mem_if.req_addr} < c_DEPTH);

        w_sel_we       = w_idle ? mem_if.req_we    : we_q;
        w_sel_addr     = w_idle ? mem_if.req_addr  : addr_q;
        w_sel_wdata    = w_idle ? mem_if.req_wdata : wdata_q;
        w_sel_in_range = ({1'b0, w_sel_addr} < c_DEPTH);

        // Out-of-range loads return zero; the RAM is never indexed past DEPTH.
        w_mem_rdata    = '0;
        if (w_sel_in_range) begin
            w_mem_rdata = mem_q[w_sel_addr[c_IDX_W-1:0]];
        end

        w_enter_resp   = (w_accept && (LATENCY == 1)) ||
                         ((state_q == S_WAIT) && (cnt_q == 4'd0));
    end

    // RAM write port: stores commit on their accept edge, out-of-range
    // stores are dropped.
    always_ff @(posedge clk) begin
        if (w_accept && mem_if.req_we && w_req_in_range) begin
            mem_q[mem_if.req_addr[c_IDX_W-1:0]] <= mem_if.req_wdata;
        end
    end

    // State register and datapath registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef CPU_MEM_BOUNDS_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef CPU_MEM_BOUNDS_ERR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, RESP holds until
    // the CPU takes the response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef CPU_MEM_BOUNDS_ERR_EN
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (mem_if.req_valid) begin
                    we_d    = mem_if.req_we;
                    addr_d  = mem_if.req_addr;
                    wdata_d = mem_if.req_wdata;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = c_CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (mem_if.rsp_ready) begin
                    state_d = S_IDLE;
`ifdef CPU_MEM_BOUNDS_ERR_EN
                    rsp_err_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response payload is captured once, on the edge that enters RESP,
        // and then held unchanged for the whole RESP phase.
        if (w_enter_resp) begin
            rsp_we_d    = w_sel_we;
            rsp_rdata_d = w_sel_we ? w_sel_wdata : w_mem_rdata;
`ifdef CPU_MEM_BOUNDS_ERR_EN
            rsp_err_d   = !w_sel_in_range;
`endif
        end
    end

    // Output decode from the current state and response registers.
    always_comb begin
        mem_if.req_ready = (state_q == S_IDLE);
        mem_if.rsp_valid = (state_q == S_RESP);
        busy             = (state_q != S_IDLE);
        mem_if.rsp_we    = rsp_we_q;
        mem_if.rsp_rdata = rsp_rdata_q;
`ifdef CPU_MEM_BOUNDS_ERR_EN
        mem_if.rsp_err   = rsp_err_q;
`else
        mem_if.rsp_err   = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_responder
//  Description : Self-checking bench for cpu_mem_responder. DUT A uses
//                DEPTH=200 / LATENCY=2, DUT B uses DEPTH=256 / LATENCY=1.
//                Expected responses are queued when requests are accepted
//                and compared when the DUT presents them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_mem_responder;

    localparam int DEPTH_A = 200;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 256;
    localparam int LAT_B   = 1;
    localparam int NB      = 6;

    typedef struct packed {
        logic        we;
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    logic clk;
    logic reset;
    logic busy_a;
    logic busy_b;

    int n_checks = 0;
    int n_errors = 0;

    rsp_t        exp_q   [$];
    rsp_t        exp_b_q [$];
    logic [15:0] model_a [256];
    logic [15:0] model_b [256];

    cpu_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
    cpu_mem_responder_if #(.DATA_W(16), .ADDR_W(8)) bus_b ();

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus_a),
        .busy   (busy_a)
    );

    cpu_mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH_B), .LATENCY(LAT_B)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus_b),
        .busy   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic exp_err(input logic in_range);
`ifdef CPU_MEM_BOUNDS_ERR_EN
        return !in_range;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one request on DUT A at a negedge while it is idle; returns at
    // the negedge following the accept edge with the expectation queued.
    task automatic send_req(input logic we, input logic [7:0] addr, input logic [15:0] data);
        rsp_t e;
        logic inr;
        chk("a_idle_ready", 32'(bus_a.req_ready), 32'd1);
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = data;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        inr = (int'(addr) < DEPTH_A);
        if (we && inr) model_a[addr] = data;
        e.we    = we;
        e.rdata = we ? data : (inr ? model_a[addr] : 16'h0000);
        e.err   = exp_err(inr);
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for DUT A's response, check latency and payload, apply
    // 'hold' cycles of backpressure with a competing store pulsed in, then
    // complete the handshake and check the return to IDLE.
    task automatic wait_rsp(input int hold);
        int          lat;
        rsp_t        e;
        logic [15:0] snap;
        lat = 1;
        while (bus_a.rsp_valid !== 1'b1 && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        chk("a_latency", 32'(lat), 32'(LAT_A));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_rdata", 32'(bus_a.rsp_rdata), 32'(e.rdata));
            chk("a_rsp_we", 32'(bus_a.rsp_we), 32'(e.we));
            chk("a_rsp_err", 32'(bus_a.rsp_err), 32'(e.err));
        end
        snap = e.rdata;
        bus_a.req_we    = 1'b1;
        bus_a.req_addr  = 8'h20;
        bus_a.req_wdata = 16'hDEAD;
        for (int h = 0; h < hold; h++) begin
            bus_a.req_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
            chk("bp_rdata", 32'(bus_a.rsp_rdata), 32'(snap));
            chk("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
            chk("bp_busy", 32'(busy_a), 32'd1);
        end
        bus_a.req_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        @(negedge clk);
        bus_a.rsp_ready = 1'b0;
        chk("hs_valid_low", 32'(bus_a.rsp_valid), 32'd0);
        chk("hs_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("hs_rdata_hold", 32'(bus_a.rsp_rdata), 32'(snap));
        chk("hs_err_clear", 32'(bus_a.rsp_err), 32'd0);
    endtask

    initial begin
        rsp_t eb;
        int   idx;
        logic bwe;
        logic [7:0]  baddr;
        logic [15:0] bdata;

        reset           = 1'b1;
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = 1'b0;
        bus_a.req_addr  = '0;
        bus_a.req_wdata = '0;
        bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0;
        bus_b.req_we    = 1'b0;
        bus_b.req_addr  = '0;
        bus_b.req_wdata = '0;
        bus_b.rsp_ready = 1'b0;

        // Reset with the clock running
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus_a.rsp_rdata), 32'h0000);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_err", 32'(bus_a.rsp_err), 32'd0);
        chk("rst_rsp_we", 32'(bus_a.rsp_we), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 32'(bus_a.req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
            chk("idle_rdata", 32'(bus_a.rsp_rdata), 32'h0000);
            chk("idle_busy", 32'(busy_a), 32'd0);
        end

        // Store then load back
        send_req(1'b1, 8'h05, 16'hBEEF);
        chk("wait_busy", 32'(busy_a), 32'd1);
        wait_rsp(0);
        send_req(1'b0, 8'h05, 16'h0000);
        wait_rsp(0);

        // Backpressure while a competing store to 0x20 is pulsed
        send_req(1'b1, 8'h20, 16'h1111);
        wait_rsp(0);
        send_req(1'b1, 8'h30, 16'h5A5A);
        wait_rsp(3);
        send_req(1'b0, 8'h20, 16'h0000);
        wait_rsp(0);

        // Reset during WAIT: the store is already committed
        send_req(1'b1, 8'h10, 16'h1234);
        chk("rw_busy_before", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rw_req_ready", 32'(bus_a.req_ready), 32'd1);
        chk("rw_busy", 32'(busy_a), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rw_still_idle", 32'(bus_a.rsp_valid), 32'd0);
        send_req(1'b0, 8'h10, 16'h0000);
        wait_rsp(0);

        // Bounds: 0xC8 is out of range for DEPTH=200, 0xC7 is the last word
        send_req(1'b1, 8'hC8, 16'hAAAA);
        wait_rsp(0);
        send_req(1'b0, 8'hC8, 16'h0000);
        wait_rsp(0);
        send_req(1'b1, 8'hC7, 16'h7777);
        wait_rsp(0);
        send_req(1'b0, 8'hC7, 16'h0000);
        wait_rsp(0);

        // DUT B, LATENCY=1: req_valid held, rsp_ready high, alternating
        // store/load; expect one accept every two cycles.
        bus_b.rsp_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 2 * NB + 1; cyc++) begin
            chk("b_req_ready", 32'(bus_b.req_ready), 32'((cyc % 2) == 0));
            chk("b_rsp_valid", 32'(bus_b.rsp_valid), 32'((cyc % 2) == 1));
            if ((cyc % 2) == 1 && exp_b_q.size() > 0) begin
                eb = exp_b_q.pop_front();
                chk("b_rdata", 32'(bus_b.rsp_rdata), 32'(eb.rdata));
                chk("b_rsp_we", 32'(bus_b.rsp_we), 32'(eb.we));
            end
            if ((cyc % 2) == 0) begin
                if (idx < NB) begin
                    bwe   = ((idx % 2) == 0);
                    baddr = 8'(32'h40 + idx / 2);
                    bdata = 16'(32'hA000 + idx * 32'h0111);
                    bus_b.req_valid = 1'b1;
                    bus_b.req_we    = bwe;
                    bus_b.req_addr  = baddr;
                    bus_b.req_wdata = bdata;
                    if (bwe) model_b[baddr] = bdata;
                    eb.we    = bwe;
                    eb.rdata = bwe ? bdata : model_b[baddr];
                    eb.err   = 1'b0;
                    exp_b_q.push_back(eb);
                    idx++;
                end else begin
                    bus_b.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk("b_final_idle", 32'(busy_b), 32'd0);
        chk("b_final_valid", 32'(bus_b.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
